// File: rtl/avalon_burst_arbiter.sv
// avalon_burst_arbiter
// Two-host, burst-granular round-robin arbiter in front of one Avalon-MM agent.
// Host 0 is the video stream writer and host 1 is the display/frame reader.
// A grant covers a whole burst. A write burst ends when its last beat is
// accepted. A read burst ends when its last data beat is returned. Only one
// read burst is in flight at a time.
//
// Handshake: a command or write beat transfers on a rising clk edge where the
// host's read/write is high and its waitrequest is low. A read data beat
// transfers on any edge where readdatavalid is high; readdatavalid has no
// back-pressure.
module avalon_burst_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            reset_n,

    // host 0: video stream writer
    input  logic [AW-1:0]   h0_address,
    input  logic            h0_read,
    input  logic            h0_write,
    input  logic [DW-1:0]   h0_writedata,
    input  logic [DW/8-1:0] h0_byteenable,
    input  logic [BW-1:0]   h0_burstcount,
    output logic            h0_waitrequest,
    output logic [DW-1:0]   h0_readdata,
    output logic            h0_readdatavalid,

    // host 1: display / frame reader
    input  logic [AW-1:0]   h1_address,
    input  logic            h1_read,
    input  logic            h1_write,
    input  logic [DW-1:0]   h1_writedata,
    input  logic [DW/8-1:0] h1_byteenable,
    input  logic [BW-1:0]   h1_burstcount,
    output logic            h1_waitrequest,
    output logic [DW-1:0]   h1_readdata,
    output logic            h1_readdatavalid,

    // shared agent (DRAM controller)
    output logic [AW-1:0]   a_address,
    output logic            a_read,
    output logic            a_write,
    output logic [DW-1:0]   a_writedata,
    output logic [DW/8-1:0] a_byteenable,
    output logic [BW-1:0]   a_burstcount,
    input  logic            a_waitrequest,
    input  logic [DW-1:0]   a_readdata,
    input  logic            a_readdatavalid,

    // debug
    output logic            owner,
    output logic [1:0]      o_state
);

    localparam int BEW = DW / 8;
    localparam logic [BW-1:0] ONE  = BW'(1);
    localparam logic [BW-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic [BW-1:0] r_remaining;

    // Arbitration signals, used only in IDLE.
    logic          w_req0;
    logic          w_req1;
    logic          w_any_req;
    logic          w_gnt;
    logic          w_gnt_write;
    logic [BW-1:0] w_gnt_bc;
    logic [BW-1:0] w_gnt_len;

    // Signals from the host that owns the current burst.
    logic [AW-1:0]  w_own_address;
    logic           w_own_read;
    logic           w_own_write;
    logic [DW-1:0]  w_own_writedata;
    logic [BEW-1:0] w_own_byteenable;
    logic [BW-1:0]  w_own_burstcount;

    // Beat and command events.
    logic w_in_wr;
    logic w_in_rd;
    logic w_in_cmd;
    logic w_wr_beat;
    logic w_rd_beat;
    logic w_cmd_acc;
    logic w_last;

    // Request detection and round-robin pick. On a tie, the host that did not
    // hold the last grant wins.
    always_comb begin
        w_req0    = h0_read | h0_write;
        w_req1    = h1_read | h1_write;
        w_any_req = w_req0 | w_req1;
        if (w_req0 && w_req1) begin
            w_gnt = ~r_owner;
        end else begin
            w_gnt = w_req1;
        end
        // When read and write are both high, write wins.
        w_gnt_write = w_gnt ? h1_write : h0_write;
        w_gnt_bc    = w_gnt ? h1_burstcount : h0_burstcount;
        // A burstcount of 0 is treated as a single beat.
        w_gnt_len   = (w_gnt_bc == ZERO) ? ONE : w_gnt_bc;
    end

    // Select the signals of the host that owns the current burst.
    always_comb begin
        if (r_owner) begin
            w_own_address    = h1_address;
            w_own_read       = h1_read;
            w_own_write      = h1_write;
            w_own_writedata  = h1_writedata;
            w_own_byteenable = h1_byteenable;
            w_own_burstcount = h1_burstcount;
        end else begin
            w_own_address    = h0_address;
            w_own_read       = h0_read;
            w_own_write      = h0_write;
            w_own_writedata  = h0_writedata;
            w_own_byteenable = h0_byteenable;
            w_own_burstcount = h0_burstcount;
        end
    end

    // Beat and command events that drive the FSM.
    always_comb begin
        w_in_wr   = (r_state == WR);
        w_in_cmd  = (r_state == RD_CMD);
        w_in_rd   = (r_state == RD_CMD) || (r_state == RD_DATA);
        w_wr_beat = w_in_wr && w_own_write && !a_waitrequest;
        w_cmd_acc = w_in_cmd && w_own_read && !a_waitrequest;
        // A read beat counts only while beats remain; extra beats are ignored.
        w_rd_beat = w_in_rd && a_readdatavalid && (r_remaining != ZERO);
        w_last    = (r_remaining == ONE);
    end

    // Burst FSM: grant, beat counting and return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b1;
            r_remaining <= ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_gnt;
                        r_remaining <= w_gnt_len;
                        r_state     <= w_gnt_write ? WR : RD_CMD;
                    end
                end
                WR: begin
                    if (w_wr_beat) begin
                        if (r_remaining != ZERO) begin
                            r_remaining <= r_remaining - ONE;
                        end
                        if (w_last || (r_remaining == ZERO)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD_CMD: begin
                    // A data beat that arrives with command acceptance still
                    // counts. If it is the last beat, the burst is finished.
                    if (w_rd_beat) begin
                        r_remaining <= r_remaining - ONE;
                    end
                    if (w_rd_beat && w_last) begin
                        r_state <= IDLE;
                    end else if (w_cmd_acc) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_rd_beat) begin
                        r_remaining <= r_remaining - ONE;
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Agent-side command path. The owner's signals pass through, and the
    // strobes are gated by the FSM state.
    always_comb begin
        a_address    = w_own_address;
        a_writedata  = w_own_writedata;
        a_byteenable = w_own_byteenable;
        a_burstcount = w_own_burstcount;
        a_write      = w_in_wr && w_own_write;
        a_read       = w_in_cmd && w_own_read;
    end

    // Host-side stall and read data routing. Only the owner sees the agent's
    // waitrequest or readdatavalid.
    always_comb begin
        h0_waitrequest   = 1'b1;
        h1_waitrequest   = 1'b1;
        h0_readdatavalid = 1'b0;
        h1_readdatavalid = 1'b0;
        h0_readdata      = a_readdata;
        h1_readdata      = a_readdata;
        if (w_in_wr || w_in_cmd) begin
            if (r_owner) begin
                h1_waitrequest = a_waitrequest;
            end else begin
                h0_waitrequest = a_waitrequest;
            end
        end
        if (w_in_rd && a_readdatavalid) begin
            if (r_owner) begin
                h1_readdatavalid = 1'b1;
            end else begin
                h0_readdatavalid = 1'b1;
            end
        end
    end

    // Debug outputs.
    always_comb begin
        owner   = r_owner;
        o_state = r_state;
    end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// tb_avalon_burst_arbiter
// Directed checks of latency, reset and tie-break behaviour, then randomized
// two-host traffic. The expected agent-side burst order comes from a
// round-robin merge of both hosts' burst lists.
module tb_avalon_burst_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int BEW = DW / 8;
    localparam int NB  = 12;
    localparam int LIMIT = 20000;

    // clock / reset
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // host-side signals, indexed by host number
    logic [AW-1:0]  h_addr  [2];
    logic           h_read  [2];
    logic           h_write [2];
    logic [DW-1:0]  h_wdata [2];
    logic [BEW-1:0] h_be    [2];
    logic [BW-1:0]  h_bc    [2];
    logic           h_wait  [2];
    logic [DW-1:0]  h_rdata [2];
    logic           h_rdv   [2];

    // agent-side signals
    logic [AW-1:0]  a_address;
    logic           a_read;
    logic           a_write;
    logic [DW-1:0]  a_writedata;
    logic [BEW-1:0] a_byteenable;
    logic [BW-1:0]  a_burstcount;
    logic           a_waitrequest;
    logic [DW-1:0]  a_readdata;
    logic           a_readdatavalid;
    logic           owner;
    logic [1:0]     dut_state;

    avalon_burst_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .h0_address       (h_addr[0]),
        .h0_read          (h_read[0]),
        .h0_write         (h_write[0]),
        .h0_writedata     (h_wdata[0]),
        .h0_byteenable    (h_be[0]),
        .h0_burstcount    (h_bc[0]),
        .h0_waitrequest   (h_wait[0]),
        .h0_readdata      (h_rdata[0]),
        .h0_readdatavalid (h_rdv[0]),
        .h1_address       (h_addr[1]),
        .h1_read          (h_read[1]),
        .h1_write         (h_write[1]),
        .h1_writedata     (h_wdata[1]),
        .h1_byteenable    (h_be[1]),
        .h1_burstcount    (h_bc[1]),
        .h1_waitrequest   (h_wait[1]),
        .h1_readdata      (h_rdata[1]),
        .h1_readdatavalid (h_rdv[1]),
        .a_address        (a_address),
        .a_read           (a_read),
        .a_write          (a_write),
        .a_writedata      (a_writedata),
        .a_byteenable     (a_byteenable),
        .a_burstcount     (a_burstcount),
        .a_waitrequest    (a_waitrequest),
        .a_readdata       (a_readdata),
        .a_readdatavalid  (a_readdatavalid),
        .owner            (owner),
        .o_state          (dut_state)
    );

    // scoreboard counters and checker
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: per-host burst lists and the merged grant order
    bit             b_wr   [2][NB];
    logic [AW-1:0]  b_addr [2][NB];
    logic [BW-1:0]  b_bc   [2][NB];
    logic [DW-1:0]  b_data [2][NB][8];
    logic [BEW-1:0] b_be   [2][NB][8];
    int             m_host [2*NB];
    int             m_idx  [2*NB];

    logic [DW-1:0]  exp_q0 [$];
    logic [DW-1:0]  exp_q1 [$];

    // host driver state: 0 done, 1 write burst, 2 read request, 3 read wait
    int hs_phase [2];
    int hs_bi    [2];
    int hs_beat  [2];
    int hs_left  [2];

    // agent model state
    int k_burst;
    int ag_beat;
    int rd_pending;
    int rd_lat;

    function automatic int beats(input logic [BW-1:0] bc);
        return (bc == '0) ? 1 : int'(bc);
    endfunction

    task automatic gen_bursts();
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < NB; i++) begin
                b_wr[h][i]   = ($urandom_range(0, 1) == 1);
                b_addr[h][i] = $urandom;
                b_bc[h][i]   = BW'($urandom_range(0, 8));
                for (int j = 0; j < 8; j++) begin
                    b_data[h][i][j] = $urandom;
                    b_be[h][i][j]   = BEW'($urandom_range(0, 15));
                end
            end
        end
        // Always include a burstcount-0 read and a full 8-beat read.
        b_wr[1][0] = 1'b0;
        b_bc[1][0] = '0;
        b_wr[1][1] = 1'b0;
        b_bc[1][1] = BW'(8);
    endtask

    // Both hosts always have a request pending at each arbitration point, so
    // grants alternate starting with host 0. Once one host runs out of
    // bursts, the other host takes every remaining grant.
    task automatic build_order();
        int idx [2];
        int last;
        int h;
        idx[0] = 0;
        idx[1] = 0;
        last   = 1;
        for (int n = 0; n < 2*NB; n++) begin
            if (idx[0] < NB && idx[1] < NB) h = 1 - last;
            else if (idx[0] < NB)           h = 0;
            else                            h = 1;
            m_host[n] = h;
            m_idx[n]  = idx[h];
            idx[h]++;
            last = h;
        end
    endtask

    task automatic host_next(input int h);
        int i;
        hs_bi[h]++;
        i = hs_bi[h];
        if (i < NB) begin
            h_addr[h] = b_addr[h][i];
            h_bc[h]   = b_bc[h][i];
            if (b_wr[h][i]) begin
                hs_phase[h] = 1;
                hs_beat[h]  = 0;
                h_write[h]  = 1'b1;
                h_read[h]   = 1'b0;
                h_wdata[h]  = b_data[h][i][0];
                h_be[h]     = b_be[h][i][0];
            end else begin
                hs_phase[h] = 2;
                h_write[h]  = 1'b0;
                h_read[h]   = 1'b1;
            end
        end else begin
            hs_phase[h] = 0;
            h_write[h]  = 1'b0;
            h_read[h]   = 1'b0;
        end
    endtask

    // Drive hosts and agent just after the rising edge.
    task automatic drive_tick();
        for (int h = 0; h < 2; h++) begin
            case (hs_phase[h])
                1: begin
                    if (hs_beat[h] == beats(b_bc[h][hs_bi[h]])) begin
                        host_next(h);
                    end else begin
                        h_write[h] = (hs_beat[h] == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
                        h_wdata[h] = b_data[h][hs_bi[h]][hs_beat[h]];
                        h_be[h]    = b_be[h][hs_bi[h]][hs_beat[h]];
                    end
                end
                3: begin
                    if (hs_left[h] == 0) host_next(h);
                    else h_read[h] = 1'b0;
                end
                default: ;
            endcase
        end
        a_waitrequest   = ($urandom_range(0, 3) == 0);
        a_readdatavalid = 1'b0;
        if (rd_pending > 0) begin
            if (rd_lat > 0) begin
                rd_lat--;
            end else if ($urandom_range(0, 3) != 0) begin
                a_readdatavalid = 1'b1;
                a_readdata      = $urandom;
                if (m_host[k_burst] == 0) exp_q0.push_back(a_readdata);
                else                      exp_q1.push_back(a_readdata);
                rd_pending--;
                if (rd_pending == 0) k_burst++;
            end
        end
    endtask

    // Observe the transfers that the next rising edge will commit.
    task automatic observe_tick();
        logic [DW-1:0] e;
        int h;
        int i;
        for (int hh = 0; hh < 2; hh++) begin
            if (h_rdv[hh]) begin
                if (hs_phase[hh] == 3 && hs_left[hh] > 0) begin
                    if (hh == 0 && exp_q0.size() > 0)      begin e = exp_q0.pop_front(); chk("h0_rdata", h_rdata[hh], e); end
                    else if (hh == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); chk("h1_rdata", h_rdata[hh], e); end
                    else chk("rdv_no_expected_data", 1, 0);
                    hs_left[hh]--;
                end else begin
                    chk(hh == 0 ? "h0_stray_rdv" : "h1_stray_rdv", 1, 0);
                end
            end
            if (hs_phase[hh] == 1 && h_write[hh] && !h_wait[hh]) hs_beat[hh]++;
            if (hs_phase[hh] == 2 && h_read[hh] && !h_wait[hh]) begin
                hs_phase[hh] = 3;
                hs_left[hh]  = beats(b_bc[hh][hs_bi[hh]]);
            end
        end
        if ((a_write || a_read) && !a_waitrequest) begin
            if (k_burst >= 2*NB) begin
                chk("agent_extra_cmd", 1, 0);
            end else begin
                h = m_host[k_burst];
                i = m_idx[k_burst];
                chk("burst_kind_is_write", a_write, b_wr[h][i]);
                chk("burst_addr", a_address, b_addr[h][i]);
                chk("burst_count", a_burstcount, b_bc[h][i]);
                if (a_write) begin
                    chk("wr_data", a_writedata, b_data[h][i][ag_beat]);
                    chk("wr_be", a_byteenable, b_be[h][i][ag_beat]);
                    ag_beat++;
                    if (ag_beat == beats(b_bc[h][i])) begin
                        ag_beat = 0;
                        k_burst++;
                    end
                end else begin
                    rd_pending = beats(b_bc[h][i]);
                    rd_lat     = $urandom_range(0, 3);
                end
            end
        end
    endtask

    task automatic clear_inputs();
        for (int h = 0; h < 2; h++) begin
            h_addr[h]  = '0;
            h_read[h]  = 1'b0;
            h_write[h] = 1'b0;
            h_wdata[h] = '0;
            h_be[h]    = '0;
            h_bc[h]    = '0;
        end
        a_waitrequest   = 1'b0;
        a_readdata      = '0;
        a_readdatavalid = 1'b0;
    endtask

    task automatic set_write(input int h, input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                             input logic [DW-1:0] d);
        h_addr[h]  = addr;
        h_bc[h]    = bc;
        h_wdata[h] = d;
        h_be[h]    = '1;
        h_write[h] = 1'b1;
    endtask

    logic [DW-1:0] dd [4];
    int cyc;
    bit done;

    initial begin
        // clock/reset block
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_owner", owner, 1);
        chk("rst_h0_wait", h_wait[0], 1);
        chk("rst_h1_wait", h_wait[1], 1);
        chk("rst_a_write", a_write, 0);
        chk("rst_a_read", a_read, 0);
        chk("rst_h0_rdv", h_rdv[0], 0);
        chk("rst_h1_rdv", h_rdv[1], 0);
        chk("rst_state", dut_state, 0);
        reset_n = 1'b1;

        // Host 0 writes 4 beats with no stalls.
        for (int j = 0; j < 4; j++) dd[j] = $urandom;
        @(posedge clk); #1;
        set_write(0, 32'h100, 8'd4, dd[0]);
        @(negedge clk);
        chk("lat_idle_a_write", a_write, 0);
        chk("lat_idle_h0_wait", h_wait[0], 1);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            h_wdata[0] = dd[j];
            @(negedge clk);
            chk("d1_a_write", a_write, 1);
            chk("d1_wdata", a_writedata, dd[j]);
            chk("d1_owner", owner, 0);
            chk("d1_h0_wait", h_wait[0], 0);
            chk("d1_h1_wait", h_wait[1], 1);
        end
        @(posedge clk); #1;
        h_write[0] = 1'b0;
        @(negedge clk);
        chk("d1_end_a_write", a_write, 0);
        chk("d1_end_state_idle", dut_state, 0);

        // Reset during beat 2 of a 4-beat write, then a contended grant.
        for (int j = 0; j < 4; j++) dd[j] = $urandom;
        @(posedge clk); #1;
        set_write(0, 32'h200, 8'd4, dd[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        h_wdata[0] = dd[1];
        @(negedge clk);
        chk("d2_beat2_wdata", a_writedata, dd[1]);
        chk("d2_beat2_a_write", a_write, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("d2_rst_a_write", a_write, 0);
        chk("d2_rst_h0_wait", h_wait[0], 1);
        chk("d2_rst_h1_wait", h_wait[1], 1);
        chk("d2_rst_owner", owner, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_write(0, 32'h300, 8'd1, dd[2]);
        set_write(1, 32'h400, 8'd1, dd[3]);
        @(negedge clk);
        chk("d2_idle_a_write", a_write, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d2_first_owner", owner, 0);
        chk("d2_first_wdata", a_writedata, dd[2]);
        @(posedge clk); #1;
        h_write[0] = 1'b0;
        @(negedge clk);
        chk("d2_turnaround_a_write", a_write, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d2_second_owner", owner, 1);
        chk("d2_second_wdata", a_writedata, dd[3]);
        chk("d2_second_h1_wait", h_wait[1], 0);
        @(posedge clk); #1;
        h_write[1] = 1'b0;

        // Randomized two-host traffic.
        reset_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        gen_bursts();
        build_order();
        k_burst    = 0;
        ag_beat    = 0;
        rd_pending = 0;
        rd_lat     = 0;
        for (int h = 0; h < 2; h++) begin
            hs_bi[h]   = -1;
            hs_beat[h] = 0;
            hs_left[h] = 0;
            host_next(h);
        end
        cyc  = 0;
        done = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            observe_tick();
            @(posedge clk); #1;
            drive_tick();
            cyc++;
            done = (k_burst == 2*NB) && (hs_phase[0] == 0) && (hs_phase[1] == 0);
        end
        chk("rand_completed_in_budget", done, 1);
        chk("rand_bursts_served", k_burst, 2*NB);
        chk("rand_q0_empty", exp_q0.size(), 0);
        chk("rand_q1_empty", exp_q1.size(), 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
